// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order instruction queue and issue sequencer that sits
// between instruction fetch and the Tomasulo back end (ROB, RS, LSB).
// Fetched words are buffered in a circular queue. The head word is shown to
// an external combinational decoder, and the decoded fields are registered
// into a one-cycle issue pulse aimed at either the RS or the LSB.
// Optional feature macro: ISSUE_STALL_STAT_EN adds per-resource stall
// counters (stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt).
module issue_ctrl #(
   parameter int IQ_DEPTH = 16,
   parameter int IQ_AW    = 4,
   parameter int OPTYPE_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rob_clear,
   input  logic                if_valid,
   input  logic [31:0]         if_instr,
   input  logic [31:0]         if_pc,
   output logic                iq_full,
   output logic [31:0]         dec_instr,
   input  logic                dec_is_ls,
   input  logic                dec_is_jump,
   input  logic [OPTYPE_W-1:0] dec_optype,
   input  logic [4:0]          dec_rd,
   input  logic [4:0]          dec_rs1,
   input  logic [4:0]          dec_rs2,
   input  logic [31:0]         dec_imm,
   input  logic                rob_full,
   input  logic                rs_full,
   input  logic                lsb_full,
   output logic                issue_valid,
   output logic                issue_to_lsb,
   output logic                issue_is_jump,
   output logic [OPTYPE_W-1:0] issue_optype,
   output logic [4:0]          issue_rd,
   output logic [4:0]          issue_rs1,
   output logic [4:0]          issue_rs2,
   output logic [31:0]         issue_imm,
   output logic [31:0]         issue_pc
`ifdef ISSUE_STALL_STAT_EN
   ,
   output logic [31:0]         stall_rob_cnt,
   output logic [31:0]         stall_rs_cnt,
   output logic [31:0]         stall_lsb_cnt
`endif
);

   localparam logic [IQ_AW:0]   FULL_CNT = IQ_DEPTH[IQ_AW:0];
   localparam logic [IQ_AW:0]   CNT_ONE  = {{IQ_AW{1'b0}}, 1'b1};
   localparam logic [IQ_AW-1:0] PTR_ONE  = {{(IQ_AW-1){1'b0}}, 1'b1};

   logic [31:0]      iq_instr [IQ_DEPTH];
   logic [31:0]      iq_pc    [IQ_DEPTH];
   logic [IQ_AW-1:0] head;
   logic [IQ_AW-1:0] tail;
   logic [IQ_AW:0]   count;
   logic             non_empty;
   logic             push;
   logic             target_free;
   logic             issue_go;

   // Queue status, push/issue qualification and the decoder-facing head word
   always_comb begin
      non_empty   = (count != '0);
      iq_full     = (count == FULL_CNT);
      push        = if_valid && !iq_full && rdy && !rob_clear;
      target_free = dec_is_ls ? !lsb_full : !rs_full;
      issue_go    = rdy && !rob_clear && non_empty && !rob_full && target_free;
      dec_instr   = non_empty ? iq_instr[head] : 32'h0;
   end

   // Queue storage is written at the tail; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) begin
         iq_instr[tail] <= if_instr;
         iq_pc[tail]    <= if_pc;
      end
   end

   // Pointers and occupancy; a flush empties the queue and beats any push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy) begin
         if (rob_clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               tail <= tail + PTR_ONE;
            end
            if (issue_go) begin
               head <= head + PTR_ONE;
            end
            if (push && !issue_go) begin
               count <= count + CNT_ONE;
            end else if (!push && issue_go) begin
               count <= count - CNT_ONE;
            end
         end
      end
   end

   // Issue register: pulse for one cycle per issue, data fields hold on stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid   <= 1'b0;
         issue_to_lsb  <= 1'b0;
         issue_is_jump <= 1'b0;
         issue_optype  <= '0;
         issue_rd      <= '0;
         issue_rs1     <= '0;
         issue_rs2     <= '0;
         issue_imm     <= '0;
         issue_pc      <= '0;
      end else if (rdy) begin
         issue_valid <= issue_go;
         if (issue_go) begin
            issue_to_lsb  <= dec_is_ls;
            issue_is_jump <= dec_is_jump;
            issue_optype  <= dec_optype;
            issue_rd      <= dec_rd;
            issue_rs1     <= dec_rs1;
            issue_rs2     <= dec_rs2;
            issue_imm     <= dec_imm;
            issue_pc      <= iq_pc[head];
         end
      end
   end

`ifdef ISSUE_STALL_STAT_EN
   // Stall attribution: a full ROB is blamed first, else the targeted station
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_rob_cnt <= '0;
         stall_rs_cnt  <= '0;
         stall_lsb_cnt <= '0;
      end else if (rdy && non_empty && !rob_clear) begin
         if (rob_full) begin
            if (stall_rob_cnt != 32'hFFFF_FFFF) begin
               stall_rob_cnt <= stall_rob_cnt + 32'd1;
            end
         end else if (dec_is_ls && lsb_full) begin
            if (stall_lsb_cnt != 32'hFFFF_FFFF) begin
               stall_lsb_cnt <= stall_lsb_cnt + 32'd1;
            end
         end else if (!dec_is_ls && rs_full) begin
            if (stall_rs_cnt != 32'hFFFF_FFFF) begin
               stall_rs_cnt <= stall_rs_cnt + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order instruction queue and issue sequencer placed between instruction fetch and the Tomasulo back end (ROB, RS, LSB).
- Buffers fetched words and presents the queue head to the combinational decoder.
- Consumes the decoder's fields and issues one decoded instruction per cycle to the RS or the LSB, stalling on structural hazards and flushing on ROB clear.

Parameters:
- IQ_DEPTH, 16, instruction queue entries; power of two, at least 2.
- IQ_AW, 4, pointer width; equals log2(IQ_DEPTH).
- OPTYPE_W, 6, width of the decoder optype code.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- rob_clear  in  1  mispredict flush
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction word
- if_pc  in  32  PC of if_instr
- iq_full  out  1  queue cannot accept a push this cycle
- dec_instr  out  32  queue-head word to decoder; 0 when empty
- dec_is_ls  in  1  decoder: load/store
- dec_is_jump  in  1  decoder: JAL/JALR/branch
- dec_optype  in  OPTYPE_W  decoder optype
- dec_rd, dec_rs1, dec_rs2  in  5 each  decoder register fields
- dec_imm  in  32  decoder immediate
- rob_full, rs_full, lsb_full  in  1 each  back-end full flags
- issue_valid  out  1  one-cycle issue pulse
- issue_to_lsb  out  1  1 = LSB target, 0 = RS target
- issue_is_jump  out  1  registered dec_is_jump
- issue_optype  out  OPTYPE_W  registered optype
- issue_rd, issue_rs1, issue_rs2  out  5 each  registered register fields
- issue_imm  out  32  registered immediate
- issue_pc  out  32  PC of the issued instruction

Behaviour:
- Reset:
  - head, tail and count = 0.
  - All issue_* outputs = 0.
  - iq_full = 0.
  - Queue storage need not be reset.
- Queue:
  - Circular buffer; pointers wrap modulo IQ_DEPTH.
  - count is IQ_AW+1 bits wide.
  - iq_full is combinational: (count == IQ_DEPTH).
- Push: if_valid && !iq_full && rdy && !rob_clear.
  - Writes {if_pc, if_instr} at tail; tail increments.
  - A push attempted while full is dropped silently, even if a pop happens in the same cycle.
- dec_instr: combinational queue-head word when count > 0, else 32'h0.
- Issue condition: rdy && !rob_clear && count > 0 && !rob_full && (dec_is_ls ? !lsb_full : !rs_full).
  - On issue: head increments.
  - Next cycle: issue_valid = 1, issue_to_lsb = dec_is_ls, and all dec_* fields plus the head PC are registered into issue_*.
  - Issue latency: queue head to issue_valid is 1 cycle.
  - Throughput: 1 instruction per cycle.
- Stall:
  - When the issue condition is false and rdy = 1, issue_valid = 0 next cycle.
  - issue_* data fields hold their last values.
- Simultaneous push and issue: count unchanged, both pointers advance.
  - Also applies at count = 1: the pushed entry becomes head next cycle.
- Empty push: a word pushed at count = 0 is issued no earlier than the following cycle. There is no bypass.
- rob_clear has highest priority:
  - head = tail = count = 0 and issue_valid = 0 next cycle.
  - The same-cycle push and issue are discarded.
  - rob_clear is honoured only when rdy = 1.
- rdy = 0: pointers, count and all registered outputs hold. issue_valid holds its value; the back end qualifies it with rdy.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- The controller does not interpret optype; routing depends only on dec_is_ls.

Optional Feature:
- Macro: ISSUE_STALL_STAT_EN.
- Defined:
  - Adds outputs stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt, each 32 bits, reset to 0.
  - Each saturating counter increments in a cycle with rdy = 1, count > 0 and !rob_clear when its resource blocks issue.
  - rob_full takes priority in attribution: at most one counter increments per cycle.
  - Counters are not cleared by rob_clear.
- Undefined: these ports and their logic are absent. Issue behaviour is identical either way.

Test Plan:
- Reset, then push ADDI x1,x0,5 (0x00500093) at PC 0x0 with all full flags low -> one cycle later issue_valid = 1, issue_to_lsb = 0, issue_rd = 1, issue_imm = 5, issue_pc = 0x0.
- Push SW x2,8(x1) with lsb_full = 1 for 3 cycles -> issue_valid = 0 for those cycles. Release -> issue_to_lsb = 1, issue_rd = 0, issue_imm = 8 one cycle later.
- Push 16 words with rob_full = 1 -> iq_full = 1 at count 16; a 17th push is dropped. Release -> exactly 16 issues in PC order, including across pointer wrap.
- Queue holding 5 entries, assert rob_clear for 1 cycle with a concurrent push -> count = 0, dec_instr = 0, no issue_valid in the following cycle.
- Hold rdy = 0 for 4 cycles with if_valid = 1 and the queue non-empty -> count, pointers and issue_* unchanged. Resume -> normal issue.
- With ISSUE_STALL_STAT_EN: rob_full and rs_full both high for 3 cycles on an ALU head -> stall_rob_cnt = 3, stall_rs_cnt = 0.
